// File: rtl/counter_scoreboard.sv
// Reference model of the 4-bit multi-mode counter plus an output checker.
// Predicts Q/rco/load and accumulates saturating compare and mismatch counts.
module counter_scoreboard #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_,
    input  logic [1:0]       mode_sb4,
    input  logic [WIDTH-1:0] D_sb4,
    input  logic             check_en,
    input  logic [WIDTH-1:0] Q_dut,
    input  logic             rco_dut,
    input  logic             load_dut,
    output logic [WIDTH-1:0] Q_sb,
    output logic             rco_sb,
    output logic             load_sb,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cmp_count
);

    typedef enum logic [1:0] {
        MODE_UP3   = 2'b00,
        MODE_DOWN1 = 2'b01,
        MODE_UP1   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH:0]   sum3;
    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             load_next;
    logic             cmp_fail;

    assign mode = mode_e'(mode_sb4);
    // Carry out of the widened add is the +3 wrap indication.
    assign sum3 = {1'b0, Q_sb} + (WIDTH + 1)'(3);

    always_comb begin
        q_next    = Q_sb;
        rco_next  = 1'b0;
        load_next = 1'b0;
        if (enable_) begin
            case (mode)
                MODE_UP3: begin
                    q_next   = sum3[WIDTH-1:0];
                    rco_next = sum3[WIDTH];
                end
                MODE_DOWN1: begin
                    q_next   = Q_sb - WIDTH'(1);
                    rco_next = (Q_sb == '0);
                end
                MODE_UP1: begin
                    q_next   = Q_sb + WIDTH'(1);
                    rco_next = (Q_sb == '1);
                end
                MODE_LOAD: begin
                    q_next    = D_sb4;
                    load_next = 1'b1;
                end
                default: begin
                    q_next = Q_sb;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q_sb    <= '0;
            rco_sb  <= 1'b0;
            load_sb <= 1'b0;
        end else begin
            Q_sb    <= q_next;
            rco_sb  <= rco_next;
            load_sb <= load_next;
        end
    end

    // Case inequality so an X/Z on the counter side is reported as a failure.
    assign cmp_fail = ({Q_dut, rco_dut, load_dut} !== {Q_sb, rco_sb, load_sb});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch  <= 1'b0;
            err_count <= '0;
            cmp_count <= '0;
        end else if (check_en) begin
            mismatch <= cmp_fail;
            if (cmp_count != '1) begin
                cmp_count <= cmp_count + CNT_W'(1);
            end
            if (cmp_fail && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end else begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_scoreboard.sv
// Directed bench for counter_scoreboard: model sequences, checker statistics,
// counter saturation on a narrow-counter instance, and asynchronous reset.
module tb_counter_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_;
    logic [1:0]  mode_sb4;
    logic [3:0]  D_sb4;

    logic        check_en;
    logic [3:0]  Q_dut;
    logic        rco_dut;
    logic        load_dut;
    logic [3:0]  Q_sb;
    logic        rco_sb;
    logic        load_sb;
    logic        mismatch;
    logic [15:0] err_count;
    logic [15:0] cmp_count;

    logic        check_en_s;
    logic [3:0]  Q_dut_s;
    logic        rco_dut_s;
    logic        load_dut_s;
    logic [3:0]  Q_sb_s;
    logic        rco_sb_s;
    logic        load_sb_s;
    logic        mismatch_s;
    logic [1:0]  err_count_s;
    logic [1:0]  cmp_count_s;

    int checks   = 0;
    int failures = 0;

    logic [3:0] q_exp;
    logic       rco_exp;

    always #5 clk = ~clk;

    counter_scoreboard #(.WIDTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .enable_(enable_), .mode_sb4(mode_sb4), .D_sb4(D_sb4),
        .check_en(check_en), .Q_dut(Q_dut), .rco_dut(rco_dut), .load_dut(load_dut),
        .Q_sb(Q_sb), .rco_sb(rco_sb), .load_sb(load_sb), .mismatch(mismatch),
        .err_count(err_count), .cmp_count(cmp_count)
    );

    counter_scoreboard #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .enable_(enable_), .mode_sb4(mode_sb4), .D_sb4(D_sb4),
        .check_en(check_en_s), .Q_dut(Q_dut_s), .rco_dut(rco_dut_s), .load_dut(load_dut_s),
        .Q_sb(Q_sb_s), .rco_sb(rco_sb_s), .load_sb(load_sb_s), .mismatch(mismatch_s),
        .err_count(err_count_s), .cmp_count(cmp_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag, input logic [3:0] q, input logic rco, input logic load);
        check({tag, ".Q"}, 32'(Q_sb), 32'(q));
        check({tag, ".rco"}, 32'(rco_sb), 32'(rco));
        check({tag, ".load"}, 32'(load_sb), 32'(load));
    endtask

    initial begin
        reset = 1'b1; enable_ = 1'b0; mode_sb4 = 2'b00; D_sb4 = 4'h0;
        check_en = 1'b0; Q_dut = 4'h0; rco_dut = 1'b0; load_dut = 1'b0;
        check_en_s = 1'b0; Q_dut_s = 4'h0; rco_dut_s = 1'b0; load_dut_s = 1'b0;

        #2 reset = 1'b0;
        #1;
        check_model("por", 4'h0, 1'b0, 1'b0);
        check("por.err", 32'(err_count), 32'd0);
        check("por.cmp", 32'(cmp_count), 32'd0);
        step();
        reset = 1'b1;

        // Load E, then up by 1 through the wrap
        enable_ = 1'b1; mode_sb4 = 2'b11; D_sb4 = 4'hE;
        step(); check_model("ld_E", 4'hE, 1'b0, 1'b1);
        mode_sb4 = 2'b10;
        step(); check_model("up1_F", 4'hF, 1'b0, 1'b0);
        step(); check_model("up1_wrap", 4'h0, 1'b1, 1'b0);
        step(); check_model("up1_1", 4'h1, 1'b0, 1'b0);

        // Load C, then up by 3
        mode_sb4 = 2'b11; D_sb4 = 4'hC;
        step(); check_model("ld_C", 4'hC, 1'b0, 1'b1);
        mode_sb4 = 2'b00;
        step(); check_model("up3_F", 4'hF, 1'b0, 1'b0);
        step(); check_model("up3_wrap", 4'h2, 1'b1, 1'b0);
        step(); check_model("up3_5", 4'h5, 1'b0, 1'b0);

        // Load 1, then down through the wrap, then hold
        mode_sb4 = 2'b11; D_sb4 = 4'h1;
        step(); check_model("ld_1", 4'h1, 1'b0, 1'b1);
        mode_sb4 = 2'b01;
        step(); check_model("dn_0", 4'h0, 1'b0, 1'b0);
        step(); check_model("dn_wrap", 4'hF, 1'b1, 1'b0);
        enable_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_model("hold", 4'hF, 1'b0, 1'b0);
        end

        // Checker: counter outputs mirror the bench's own prediction
        enable_ = 1'b1; mode_sb4 = 2'b10; check_en = 1'b1;
        q_exp = 4'hF; rco_exp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Q_dut = q_exp; rco_dut = rco_exp; load_dut = 1'b0;
            step();
            check("chk.mismatch_lo", 32'(mismatch), 32'd0);
            rco_exp = (q_exp == 4'hF);
            q_exp = q_exp + 4'h1;
        end
        check("chk.q_track", 32'(Q_sb), 32'h9);
        Q_dut = q_exp ^ 4'h4; rco_dut = rco_exp; load_dut = 1'b0;
        step();
        check("chk.mismatch_hi", 32'(mismatch), 32'd1);
        check("chk.cmp11", 32'(cmp_count), 32'd11);
        check("chk.err1", 32'(err_count), 32'd1);
        rco_exp = (q_exp == 4'hF);
        q_exp = q_exp + 4'h1;
        Q_dut = q_exp; rco_dut = rco_exp;
        step();
        check("chk.mismatch_1cyc", 32'(mismatch), 32'd0);
        check("chk.cmp12", 32'(cmp_count), 32'd12);
        check("chk.err_hold", 32'(err_count), 32'd1);
        check_en = 1'b0; Q_dut = 4'h0;
        step(); step();
        check("chk.off_mismatch", 32'(mismatch), 32'd0);
        check("chk.off_cmp", 32'(cmp_count), 32'd12);
        check("chk.off_err", 32'(err_count), 32'd1);

        // Saturation on the 2-bit counters; X on Q_dut always mismatches
        check("sat.start_err", 32'(err_count_s), 32'd0);
        check_en_s = 1'b1; Q_dut_s = 4'bxxxx;
        step(); check("sat.err1", 32'(err_count_s), 32'd1);
        step(); check("sat.err2", 32'(err_count_s), 32'd2);
        step(); check("sat.err3", 32'(err_count_s), 32'd3);
        step(); check("sat.err4", 32'(err_count_s), 32'd3);
        step(); check("sat.err5", 32'(err_count_s), 32'd3);
        check("sat.cmp", 32'(cmp_count_s), 32'd3);
        check("sat.mismatch", 32'(mismatch_s), 32'd1);
        check_en_s = 1'b0;
        step(); step();
        check("sat.off_err", 32'(err_count_s), 32'd3);
        check("sat.off_cmp", 32'(cmp_count_s), 32'd3);
        check("sat.off_mismatch", 32'(mismatch_s), 32'd0);

        // Asynchronous reset mid-operation with Q_sb=9
        mode_sb4 = 2'b11; D_sb4 = 4'h9;
        step(); check_model("pre_rst", 4'h9, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_model("async_rst", 4'h0, 1'b0, 1'b0);
        check("async_rst.err", 32'(err_count), 32'd0);
        check("async_rst.cmp", 32'(cmp_count), 32'd0);
        check("async_rst.sat_err", 32'(err_count_s), 32'd0);
        step();
        reset = 1'b1; enable_ = 1'b1; mode_sb4 = 2'b10;
        step(); check_model("post_rst", 4'h1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_scoreboard.md
Name: counter_scoreboard

Overview:
- Cycle-accurate reference model of the 4-bit multi-mode counter used in the counter verification environment.
- Takes the same enable, mode and data stimulus as the counter under test and produces the predicted Q, rco and load.
- Also compares the predicted outputs against the counter's actual outputs and keeps mismatch and compare statistics for the bench.

Parameters:
- WIDTH, 4, counter data width (Q, D).
- CNT_W, 16, width of the error and compare counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable_  input  1  count enable, active high.
- mode_sb4  input  2  operating mode.
- D_sb4  input  WIDTH  parallel load data.
- check_en  input  1  enables comparison against the DUT.
- Q_dut  input  WIDTH  counter-under-test value.
- rco_dut  input  1  counter-under-test ripple carry out.
- load_dut  input  1  counter-under-test load flag.
- Q_sb  output  WIDTH  predicted counter value.
- rco_sb  output  1  predicted ripple carry out.
- load_sb  output  1  predicted load flag.
- mismatch  output  1  registered one-cycle pulse on a compare failure.
- err_count  output  CNT_W  number of failed compares.
- cmp_count  output  CNT_W  number of compares performed.

Behaviour:
- Reset:
  - reset low forces all outputs and registers to 0 immediately, independent of clk.
  - Release takes effect at the first rising edge with reset high.
  - Asserting reset mid-operation discards all state, including counters.
- Model (rising edge, reset high):
  - enable_=0: Q_sb holds; rco_sb=0; load_sb=0.
  - enable_=1, mode 00: Q_sb = Q_sb+3 mod 2^WIDTH; rco_sb=1 iff the addition wraps (Q_sb > 2^WIDTH-4 before update); load_sb=0.
  - enable_=1, mode 01: Q_sb = Q_sb-1 mod 2^WIDTH; rco_sb=1 iff Q_sb was 0 (wraps to all-ones); load_sb=0.
  - enable_=1, mode 10: Q_sb = Q_sb+1 mod 2^WIDTH; rco_sb=1 iff Q_sb was all-ones; load_sb=0.
  - enable_=1, mode 11: Q_sb = D_sb4; load_sb=1; rco_sb=0.
- Timing and state:
  - rco_sb and load_sb are registered, update on the same edge as Q_sb, and are valid for exactly that cycle.
  - Zero-cycle latency relative to the counter: both sample identical stimulus on the same edge.
  - No FSM beyond the Q_sb state register.
- Checker (rising edge, reset high, check_en=1):
  - Compare {Q_dut, rco_dut, load_dut} with the current {Q_sb, rco_sb, load_sb}. Both sides reflect the previous edge's update.
  - cmp_count increments by 1 per compare.
  - On any bit difference: err_count increments by 1 and mismatch=1 for the following cycle; otherwise mismatch=0.
  - Both counters saturate at 2^CNT_W-1 (no wrap).
  - check_en=0: no compare, counters hold, mismatch=0.
- Edge cases:
  - Simultaneous wrap and compare: the compare uses the pre-edge values.
  - A mode change takes effect on the edge on which it is sampled.
  - X on Q_dut counts as a mismatch (case-inequality compare).

Test Plan:
- Reset: reset=0 mid-count with Q_sb=9 -> Q_sb=0, rco_sb=0, load_sb=0, err_count=0, cmp_count=0 without waiting for a clk edge.
- Load then up by 1: mode 11, D=4'hE -> Q_sb=E, load_sb=1. Then mode 10 -> F, then 0 with rco_sb=1 on the wrap cycle only.
- Up by 3: load 4'hC, mode 00 -> C, F, 2 (rco_sb=1), 5 (rco_sb=0).
- Down: load 1, mode 01 -> 0, then F with rco_sb=1. Hold with enable_=0 for 3 cycles -> Q_sb stays F, rco_sb=0, load_sb=0.
- Checker: check_en=1, DUT outputs driven equal to the model for 10 cycles, then Q_dut corrupted for 1 cycle -> cmp_count=11, err_count=1, mismatch high exactly 1 cycle.
- Saturation (CNT_W=2 override): 5 forced mismatches -> err_count stops at 3. check_en=0 -> counters frozen.
